// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the RV32I execute stage.
// Loads read one aligned word from a single-port array; stores are posted
// into a small store buffer and drained into the array whenever no load
// occupies the port.
// Build option: define DMEM_FWD_EN for store-to-load forwarding (loads never
// wait). Without it, a load that finds the buffer non-empty waits in
// LOAD_WAIT until the buffer has fully drained.
module dmem_responder #(
  parameter int DEPTH    = 1024,
  parameter int SB_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_read_en,
  input  logic [31:0] i_read_addr,
  output logic        o_read_ready,
  output logic [31:0] o_data,
  output logic        o_data_valid,
  input  logic        i_write,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_wr_addr,
  input  logic [31:0] i_wr_data,
  output logic        o_sb_full,
  output logic        o_sb_empty,
  output logic        o_misalign,
  output logic        o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  state_t state, state_n;

  // Word array and store-buffer payload.
  logic [31:0]   mem     [DEPTH];
  logic [AW-1:0] sb_idx  [SB_DEPTH];
  logic [3:0]    sb_mask [SB_DEPTH];
  logic [31:0]   sb_data [SB_DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  // Store decode.
  logic          st_req, st_misalign;
  logic [1:0]    lane;
  logic [AW-1:0] wr_idx;
  logic [3:0]    st_mask;
  logic [31:0]   st_data;

  // Port arbitration.
  logic          load_acc, port_read, push, pop, ovf_set;
  logic [AW-1:0] rd_idx, port_idx;
  logic [31:0]   rd_word;

`ifndef DMEM_FWD_EN
  logic [AW-1:0] wait_idx;
`endif

  // Address bits that never reach the array: byte offset of loads and the
  // truncated upper bits (addresses wrap modulo DEPTH*4).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_read_addr[31:AW+2], i_read_addr[1:0],
                              i_wr_addr[31:AW+2]};

  assign lane       = i_wr_addr[1:0];
  assign wr_idx     = i_wr_addr[AW+1:2];
  assign rd_idx     = i_read_addr[AW+1:2];
  assign o_sb_full  = (count == CW'(SB_DEPTH));
  assign o_sb_empty = (count == '0);
  assign o_read_ready = (state == IDLE);

  // Store decode: alignment check, byte mask and lane-shifted data.
  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch is inferred; sequential blocks use '<='.
  always_comb begin
    st_req      = i_write && (i_size != 2'd0);
    st_misalign = 1'b0;
    st_mask     = 4'b0000;
    st_data     = 32'h0;
    case (i_size)
      2'd1: begin
        st_mask = 4'b0001 << lane;
        st_data = {24'h0, i_wr_data[7:0]} << {lane, 3'b000};
      end
      2'd2: begin
        st_misalign = st_req && lane[0];
        st_mask     = 4'b0011 << {lane[1], 1'b0};
        st_data     = {16'h0, i_wr_data[15:0]} << {lane[1], 4'b0000};
      end
      2'd3: begin
        st_misalign = st_req && (lane != 2'b00);
        st_mask     = 4'b1111;
        st_data     = i_wr_data;
      end
      default: ;
    endcase
  end

  // Port arbitration: a load reading the array wins, otherwise drain the head.
  always_comb begin
    load_acc = i_read_en && (state == IDLE);
`ifdef DMEM_FWD_EN
    port_read = load_acc;
    port_idx  = rd_idx;
`else
    // A load that must wait does not touch the port, so draining proceeds.
    port_read = (load_acc && o_sb_empty) || ((state == LOAD_WAIT) && o_sb_empty);
    port_idx  = (state == LOAD_WAIT) ? wait_idx : rd_idx;
`endif
    pop     = !o_sb_empty && !port_read;
    // A pop frees the head slot before the push, so a full buffer still
    // accepts a store in a draining cycle.
    push    = st_req && !st_misalign && (!o_sb_full || pop);
    ovf_set = st_req && !st_misalign && o_sb_full && !pop;
  end

  // Array read, overlaid with matching buffered stores when forwarding.
  always_comb begin
    logic [PW-1:0] slot;
    slot    = '0;
    rd_word = mem[port_idx];
`ifdef DMEM_FWD_EN
    // Oldest to youngest, so the youngest store wins each byte lane.
    for (int i = 0; i < SB_DEPTH; i++) begin
      slot = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (sb_idx[slot] == port_idx)) begin
        for (int b = 0; b < 4; b++) begin
          if (sb_mask[slot][b]) rd_word[8*b +: 8] = sb_data[slot][8*b +: 8];
        end
      end
    end
`endif
  end

  // Next-state logic: IDLE / LOAD_WAIT.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (load_acc && !port_read) state_n = LOAD_WAIT;
      LOAD_WAIT: if (o_sb_empty) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Control state, buffer pointers and registered outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= IDLE;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      o_data       <= 32'h0;
      o_data_valid <= 1'b0;
      o_misalign   <= 1'b0;
      o_overflow   <= 1'b0;
`ifndef DMEM_FWD_EN
      wait_idx     <= '0;
`endif
    end else begin
      state        <= state_n;
      o_data_valid <= port_read;
      o_misalign   <= st_misalign;
      if (port_read) o_data <= rd_word;
      if (ovf_set) o_overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
`ifndef DMEM_FWD_EN
      if (load_acc && !port_read) wait_idx <= rd_idx;
`endif
    end
  end

  // Store-buffer payload write at the tail.
  // NOTE: the buffer payload and the word array are plain storage without
  // reset; validity comes from the reset pointers and count.
  always_ff @(posedge i_clk) begin
    if (push) begin
      sb_idx[wr_ptr]  <= wr_idx;
      sb_mask[wr_ptr] <= st_mask;
      sb_data[wr_ptr] <= st_data;
    end
  end

  // Drain: write only the masked bytes of the head entry into the array.
  always_ff @(posedge i_clk) begin
    if (pop) begin
      for (int b = 0; b < 4; b++) begin
        if (sb_mask[rd_ptr][b]) mem[sb_idx[rd_ptr]][8*b +: 8] <= sb_data[rd_ptr][8*b +: 8];
      end
    end
  end

endmodule
